tbuf_bus_rx: RTL and testbench

//  Receiving end of the shared single-wire feedback bus driven by N tri-state buffers.

---
 rtl/tbuf_bus_rx.sv | 131 +++++++++++++
 tb/tb_tbuf_bus_rx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tbuf_bus_rx.sv
// Receiver for a shared single-wire bus driven by N tri-state buffers: walks the active-low
// enables one slot at a time with a turnaround gap, samples each driver, delivers a word.
// Optional 2-of-3 sample voting per slot is enabled with `define TBUF_RX_MAJORITY_EN.
module tbuf_bus_rx #(
  parameter int N_DRIVERS = 8,
  parameter int SETTLE    = 2
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 scan_en,
  input  logic                 bus_in,
  output logic [N_DRIVERS-1:0] ctrlb,
  output logic [N_DRIVERS-1:0] word_out,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 busy
);

  localparam int SW = $clog2(N_DRIVERS);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, GAP, DONE} state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        slot_q, slot_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [N_DRIVERS-1:0] cap_q, cap_d;
  logic                 load;
  logic                 sample;

`ifdef TBUF_RX_MAJORITY_EN
  // Two earlier samples of the current slot; the third is taken live on the last settle cycle.
  logic [1:0] hist_q, hist_d;

  if (SETTLE < 3) begin : g_settle_chk
    $error("tbuf_bus_rx: SETTLE must be >= 3 when majority voting is enabled");
  end
`endif

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    load    = 1'b0;
`ifdef TBUF_RX_MAJORITY_EN
    hist_d  = hist_q;
    sample  = (hist_q[0] & hist_q[1]) | (hist_q[0] & bus_in) | (hist_q[1] & bus_in);
`else
    sample  = bus_in;
`endif
    case (state_q)
      IDLE: begin
        if (scan_en) begin
          state_d = DRIVE;
          slot_d  = '0;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
`ifdef TBUF_RX_MAJORITY_EN
        if (cnt_q == CW'(SETTLE - 3)) hist_d[0] = bus_in;
        if (cnt_q == CW'(SETTLE - 2)) hist_d[1] = bus_in;
`endif
        if (cnt_q == CW'(SETTLE - 1)) begin
          cap_d[slot_q] = sample;
          state_d       = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        cnt_d = '0;
        if (slot_q == SW'(N_DRIVERS - 1)) begin
          state_d = DONE;
        end else begin
          slot_d  = slot_q + 1'b1;
          state_d = DRIVE;
        end
      end
      DONE: begin
        // Hold the finished word here rather than overwrite one the consumer has not taken.
        if (!word_valid || word_ready) begin
          load    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      cnt_q      <= '0;
      cap_q      <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
`ifdef TBUF_RX_MAJORITY_EN
      hist_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
`ifdef TBUF_RX_MAJORITY_EN
      hist_q  <= hist_d;
`endif
      if (load) begin
        word_out   <= cap_q;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    ctrlb = '1;
    if (state_q == DRIVE) begin
      for (int unsigned i = 0; i < N_DRIVERS; i++) begin
        if (slot_q == SW'(i)) ctrlb[i] = 1'b0;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_tbuf_bus_rx.sv
// Directed bench for tbuf_bus_rx: table of bus patterns plus hand-written sequences for
// mid-scan reset, backpressure and early scan_en release; a monitor watches enable overlap.
module tb_tbuf_bus_rx;

  localparam int N = 8;
`ifdef TBUF_RX_MAJORITY_EN
  localparam int SETTLE = 3;
  localparam logic [7:0] GLITCH_EXP = 8'hA5;
`else
  localparam int SETTLE = 2;
  localparam logic [7:0] GLITCH_EXP = 8'hA1;
`endif
  // edges from the IDLE-exit edge to word_valid high: 25 for SETTLE=2
  localparam int LAT = N * (SETTLE + 1) + 1;

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic         scan_en = 1'b0;
  logic         word_ready = 1'b0;
  logic         bus_in;
  logic [N-1:0] ctrlb;
  logic [N-1:0] word_out;
  logic         word_valid;
  logic         busy;

  tbuf_bus_rx #(.N_DRIVERS(N), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .scan_en   (scan_en),
    .bus_in    (bus_in),
    .ctrlb     (ctrlb),
    .word_out  (word_out),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Bus model: enabled driver puts pat[i] on the wire, pull-up otherwise; optional glitch
  // on driver 2 during its second enabled cycle.
  logic [N-1:0] pat = '0;
  logic         glitch = 1'b0;
  int           en_run = 0;

  always_comb begin
    bus_in = 1'b1;
    for (int i = 0; i < N; i++)
      if (!ctrlb[i]) bus_in = pat[i];
    if (glitch && !ctrlb[2] && en_run == 1) bus_in = ~bus_in;
  end

  always @(posedge clk) en_run <= (ctrlb != '1) ? en_run + 1 : 0;

  int           viol = 0;
  int           nxt = 0;
  logic [N-1:0] prev_c = '1;

  always @(negedge clk) begin : mon
    logic bad;
    if (!rstb) begin
      nxt    <= 0;
      prev_c <= '1;
    end else begin
      bad = 1'b0;
      if ($countones(~ctrlb) > 1) bad = 1'b1;
      if (prev_c != '1 && ctrlb != '1 && prev_c != ctrlb) bad = 1'b1;
      if (prev_c == '1 && ctrlb != '1) begin
        if (ctrlb != ~(8'h01 << nxt)) bad = 1'b1;
        nxt <= (nxt + 1) % N;
      end
      if (bad) viol <= viol + 1;
      prev_c <= ctrlb;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!word_valid && cyc < 200);
  endtask

  task automatic wait_slot(input int s);
    int cyc;
    cyc = 0;
    while (ctrlb[s] !== 1'b0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  typedef struct {
    logic [7:0] pat;
    logic       glitch;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[7];

  initial begin
    int cyc;
    vt[0] = '{8'hA5, 1'b0, 8'hA5};
    vt[1] = '{8'h3C, 1'b0, 8'h3C};
    vt[2] = '{8'h00, 1'b0, 8'h00};
    vt[3] = '{8'hFF, 1'b0, 8'hFF};
    vt[4] = '{8'h5A, 1'b0, 8'h5A};
    vt[5] = '{8'h80, 1'b0, 8'h80};
    vt[6] = '{8'hA5, 1'b1, GLITCH_EXP};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrlb", ctrlb, 8'hFF);
    chk("rst_valid", word_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_word", word_out, 8'h00);
    @(negedge clk) rstb = 1'b1;

    // reset during DRIVE discards the partial scan
    pat = 8'hFF;
    @(negedge clk) scan_en = 1'b1;
    @(negedge clk) scan_en = 1'b0;
    wait_slot(3);
    chk("mid_slot3", ctrlb, 8'hF7);
    rstb = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ctrlb", ctrlb, 8'hFF);
    chk("mid_rst_valid", word_valid, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk);
    @(negedge clk) rstb = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", busy, 0);

    word_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      pat     = vt[i].pat;
      glitch  = vt[i].glitch;
      scan_en = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("v%0d_start", i), busy, 1);
      @(negedge clk) scan_en = 1'b0;
      wait_valid(cyc);
      chk($sformatf("v%0d_lat", i), cyc, LAT);
      chk($sformatf("v%0d_word", i), word_out, vt[i].exp);
      chk($sformatf("v%0d_idle", i), busy, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_drop", i), word_valid, 0);
      glitch = 1'b0;
    end

    // backpressure: second word stalls in DONE until the first is taken
    @(negedge clk);
    word_ready = 1'b0;
    pat        = 8'h3C;
    scan_en    = 1'b1;
    @(posedge clk); #1;
    wait_valid(cyc);
    chk("bp_lat", cyc, LAT);
    chk("bp_word1", word_out, 8'h3C);
    pat = 8'hC3;
    wait_slot(0);
    scan_en = 1'b0;
    repeat (40) @(negedge clk);
    chk("bp_hold_valid", word_valid, 1);
    chk("bp_hold_word", word_out, 8'h3C);
    chk("bp_stall_busy", busy, 1);
    chk("bp_stall_ctrlb", ctrlb, 8'hFF);
    word_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_reload_valid", word_valid, 1);
    chk("bp_reload_word", word_out, 8'hC3);
    chk("bp_reload_idle", busy, 0);
    @(negedge clk) word_ready = 1'b0;
    @(posedge clk); #1;
    chk("bp_keep_valid", word_valid, 1);
    chk("bp_keep_word", word_out, 8'hC3);
    @(negedge clk) word_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_clear", word_valid, 0);

    // scan_en released at slot 3: word still completes, then the FSM parks
    @(negedge clk);
    pat     = 8'h96;
    scan_en = 1'b1;
    wait_slot(3);
    scan_en = 1'b0;
    wait_valid(cyc);
    chk("stop_valid", word_valid, 1);
    chk("stop_word", word_out, 8'h96);
    repeat (5) @(posedge clk);
    #1;
    chk("stop_busy", busy, 0);
    chk("stop_ctrlb", ctrlb, 8'hFF);
    chk("stop_valid_low", word_valid, 0);

    chk("contention", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
